// File: rtl/game_pkg.sv
// Types and constants shared by the Pong match sequencer and its helpers.
package game_pkg;
  localparam int SCORE_W = 4;

  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4,
    PAUSE = 3'd5
  } game_state_t;
endpackage

// File: rtl/vga_pkg.sv
// Shared VGA timing geometry (visible area only) used by the Pong datapath blocks.
package vga_pkg;
  localparam int unsigned HOR_PIXELS = 800;
  localparam int unsigned VER_PIXELS = 600;
endpackage

// File: rtl/serve_timer.sv
// Serve delay counter: counts enabled cycles and wraps to zero on its terminal count.
module serve_timer #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);
  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= done ? '0 : r_cnt + 1'b1;
    end
  end

  assign done = (r_cnt == LAST);
endmodule

// File: rtl/game_ctl.sv
// Pong match sequencer: serve/play/point/over phases, miss detection and scoring.
// Optional GAME_CTL_PAUSE_EN adds a pause input and a PAUSE state.
module game_ctl
  import game_pkg::*;
#(
  parameter int unsigned SERVE_CYCLES = 65_000_000,
  parameter int unsigned WIN_SCORE    = 11,
  parameter int unsigned H_LIMIT      = vga_pkg::HOR_PIXELS,
  parameter int unsigned WRAP_X       = 2040
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef GAME_CTL_PAUSE_EN
  input  logic               pause,
`endif
  input  logic [10:0]        ball_xpos,
  output logic               ball_rst,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [2:0]         game_state,
  output logic               game_over,
  output logic               winner
);
  localparam logic [10:0]        LP_H_LIMIT = 11'(H_LIMIT);
  localparam logic [10:0]        LP_WRAP_X  = 11'(WRAP_X);
  localparam logic [SCORE_W-1:0] LP_WIN     = SCORE_W'(WIN_SCORE);

  game_state_t        r_state;
  game_state_t        w_next;
  logic               r_start_q;
  logic               r_scorer;
  logic [SCORE_W-1:0] r_score_l;
  logic [SCORE_W-1:0] r_score_r;
  logic               r_ball_rst;
  logic               r_game_over;
  logic               r_winner;

  logic               w_start_rise;
  logic               w_left_miss;
  logic               w_right_miss;
  logic               w_serve_done;
  logic               w_pause;
  logic [SCORE_W-1:0] w_score_inc;
  logic               w_win;
  logic [SCORE_W-1:0] w_score_l_nxt;
  logic [SCORE_W-1:0] w_score_r_nxt;
  logic               w_winner_nxt;
  logic               w_ball_rst_nxt;
  logic               w_game_over_nxt;

`ifdef GAME_CTL_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  assign w_start_rise = start & ~r_start_q;
  // An x that underflowed past 0 wraps to the top of the 11-bit range.
  assign w_left_miss  = (ball_xpos == '0) || (ball_xpos >= LP_WRAP_X);
  assign w_right_miss = (ball_xpos >= LP_H_LIMIT) && (ball_xpos < LP_WRAP_X);

  assign w_score_inc = ((r_scorer == SIDE_LEFT) ? r_score_l : r_score_r) + 1'b1;
  assign w_win       = (w_score_inc == LP_WIN);

  // Counter is held clear outside SERVE, so every serve starts from zero.
  serve_timer #(
    .CYCLES (SERVE_CYCLES)
  ) u_serve_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (r_state != SERVE),
    .en    (r_state == SERVE),
    .done  (w_serve_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_start_rise) w_next = SERVE;
      SERVE: if (w_serve_done) w_next = PLAY;
      PLAY: begin
        if (w_pause) begin
          w_next = PAUSE;
        end else if (w_left_miss || w_right_miss) begin
          w_next = POINT;
        end
      end
      POINT: w_next = w_win ? OVER : SERVE;
      OVER:  if (w_start_rise) w_next = SERVE;
`ifdef GAME_CTL_PAUSE_EN
      PAUSE: if (!w_pause) w_next = SERVE;
`endif
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_score_l_nxt = r_score_l;
    w_score_r_nxt = r_score_r;
    w_winner_nxt  = r_winner;
    if (r_state == POINT) begin
      if (r_scorer == SIDE_LEFT) begin
        w_score_l_nxt = w_score_inc;
      end else begin
        w_score_r_nxt = w_score_inc;
      end
      if (w_win) begin
        w_winner_nxt = r_scorer;
      end
    end else if ((r_state == OVER) && w_start_rise) begin
      w_score_l_nxt = '0;
      w_score_r_nxt = '0;
    end
    w_ball_rst_nxt  = (w_next != PLAY);
    w_game_over_nxt = (w_next == OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q   <= 1'b0;
      r_scorer    <= SIDE_LEFT;
      r_score_l   <= '0;
      r_score_r   <= '0;
      r_ball_rst  <= 1'b1;
      r_game_over <= 1'b0;
      r_winner    <= SIDE_LEFT;
    end else begin
      r_start_q   <= start;
      if (r_state == PLAY) begin
        r_scorer <= w_left_miss ? SIDE_RIGHT : SIDE_LEFT;
      end
      r_score_l   <= w_score_l_nxt;
      r_score_r   <= w_score_r_nxt;
      r_ball_rst  <= w_ball_rst_nxt;
      r_game_over <= w_game_over_nxt;
      r_winner    <= w_winner_nxt;
    end
  end

  assign ball_rst   = r_ball_rst;
  assign score_l    = r_score_l;
  assign score_r    = r_score_r;
  assign game_state = r_state;
  assign game_over  = r_game_over;
  assign winner     = r_winner;
endmodule

// File: tb/tb_game_ctl.sv
// Self-checking bench for game_ctl: scenario tasks against a score/phase reference model.
module tb_game_ctl;
  localparam int SC = 4;
  localparam int WS = 3;
  localparam int HL = 800;
  localparam int WX = 2040;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;
  localparam logic [2:0] S_PAUSE = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [10:0] ball_xpos;
  logic        ball_rst;
  logic [3:0]  score_l;
  logic [3:0]  score_r;
  logic [2:0]  game_state;
  logic        game_over;
  logic        winner;
`ifdef GAME_CTL_PAUSE_EN
  logic        pause;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int m_l = 0;
  int m_r = 0;
  logic m_over = 1'b0;
  logic m_win = 1'b0;

  always #5 clk = ~clk;

  game_ctl #(
    .SERVE_CYCLES (SC),
    .WIN_SCORE    (WS),
    .H_LIMIT      (HL),
    .WRAP_X       (WX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
`ifdef GAME_CTL_PAUSE_EN
    .pause      (pause),
`endif
    .ball_xpos  (ball_xpos),
    .ball_rst   (ball_rst),
    .score_l    (score_l),
    .score_r    (score_r),
    .game_state (game_state),
    .game_over  (game_over),
    .winner     (winner)
  );

  // Who scores for a given x: 0 nobody, 1 left player, 2 right player.
  function automatic int miss_side(input int x);
    if (x == 0 || x >= WX) return 2;
    if (x >= HL) return 1;
    return 0;
  endfunction

  function automatic logic [12:0] obs();
    return {game_state, ball_rst, score_l, score_r, game_over};
  endfunction

  function automatic logic [12:0] expv(input logic [2:0] st, input logic br,
                                       input int l, input int r, input logic ov);
    return {st, br, 4'(l), 4'(r), ov};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic play_point(input int x);
    int side;
    logic [12:0] e;
    side = miss_side(x);
    ball_xpos = 11'(x);
    tick();
    if (side == 0) begin
      e = expv(S_PLAY, 1'b0, m_l, m_r, 1'b0);
      n_cmp++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL no_miss x=%0d got=%h want=%h", x, obs(), e);
      end
      return;
    end
    e = expv(S_POINT, 1'b1, m_l, m_r, 1'b0);
    n_cmp++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL point_entry x=%0d got=%h want=%h", x, obs(), e);
    end
    ball_xpos = 11'd400;
    if (side == 1) m_l++;
    else m_r++;
    m_over = (m_l == WS) || (m_r == WS);
    if (m_over) m_win = (side == 2);
    tick();
    e = expv(m_over ? S_OVER : S_SERVE, 1'b1, m_l, m_r, m_over);
    n_cmp++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL score_update x=%0d got=%h want=%h", x, obs(), e);
    end
    if (m_over) begin
      n_cmp++;
      if (winner !== m_win) begin
        n_fail++;
        $display("FAIL winner x=%0d got=%b want=%b", x, winner, m_win);
      end
      return;
    end
    repeat (SC - 1) tick();
    e = expv(S_SERVE, 1'b1, m_l, m_r, 1'b0);
    n_cmp++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL serve_hold x=%0d got=%h want=%h", x, obs(), e);
    end
    tick();
    e = expv(S_PLAY, 1'b0, m_l, m_r, 1'b0);
    n_cmp++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL replay x=%0d got=%h want=%h", x, obs(), e);
    end
  endtask

  task automatic over_and_restart();
    logic [13:0] e;
    ball_xpos = 11'd800;
    repeat (2) tick();
    ball_xpos = 11'd0;
    tick();
    e = {expv(S_OVER, 1'b1, m_l, m_r, 1'b1), m_win};
    n_cmp++;
    if ({obs(), winner} !== e) begin
      n_fail++;
      $display("FAIL over_frozen got=%h want=%h", {obs(), winner}, e);
    end
    start = 1'b1;
    ball_xpos = 11'd400;
    tick();
    start = 1'b0;
    m_l = 0;
    m_r = 0;
    m_over = 1'b0;
    n_cmp++;
    if (obs() !== expv(S_SERVE, 1'b1, 0, 0, 1'b0)) begin
      n_fail++;
      $display("FAIL over_restart got=%h want=%h", obs(), expv(S_SERVE, 1'b1, 0, 0, 1'b0));
    end
    repeat (SC) tick();
    n_cmp++;
    if (obs() !== expv(S_PLAY, 1'b0, 0, 0, 1'b0)) begin
      n_fail++;
      $display("FAIL restart_play got=%h want=%h", obs(), expv(S_PLAY, 1'b0, 0, 0, 1'b0));
    end
  endtask

  task automatic restart();
    rst_n = 1'b0;
    start = 1'b0;
    ball_xpos = 11'd400;
    tick();
    rst_n = 1'b1;
    m_l = 0;
    m_r = 0;
    m_over = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (SC) tick();
    n_cmp++;
    if (obs() !== expv(S_PLAY, 1'b0, 0, 0, 1'b0)) begin
      n_fail++;
      $display("FAIL restart got=%h want=%h", obs(), expv(S_PLAY, 1'b0, 0, 0, 1'b0));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    ball_xpos = 11'd400;
    repeat (3) tick();
    n_cmp++;
    if ({obs(), winner} !== {expv(S_IDLE, 1'b1, 0, 0, 1'b0), 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values got=%h", {obs(), winner});
    end
    rst_n = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (obs() !== expv(S_IDLE, 1'b1, 0, 0, 1'b0)) begin
      n_fail++;
      $display("FAIL idle_hold got=%h want=%h", obs(), expv(S_IDLE, 1'b1, 0, 0, 1'b0));
    end
  endtask

  task automatic test_start_edge();
    logic [12:0] e;
    start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      e = (i <= SC) ? expv(S_SERVE, 1'b1, 0, 0, 1'b0) : expv(S_PLAY, 1'b0, 0, 0, 1'b0);
      n_cmp++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL start_edge cycle=%0d got=%h want=%h", i, obs(), e);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_miss_decode();
    play_point(799);
    play_point(0);
    play_point(800);
    play_point(2045);
    play_point(1);
    play_point(2039);
  endtask

  task automatic test_win();
    restart();
    repeat (3) play_point(800);
    if (m_over) over_and_restart();
    play_point(2040);
    play_point(2047);
    play_point(0);
    if (m_over) over_and_restart();
  endtask

  task automatic test_random();
    int x;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 7))
        0: x = 0;
        1: x = 799;
        2: x = 800;
        3: x = 2039;
        4: x = 2040;
        5: x = 2047;
        6: x = 1;
        default: x = int'($urandom_range(0, 2047));
      endcase
      play_point(x);
      if (m_over) over_and_restart();
    end
  endtask

  task automatic test_async_reset();
    play_point(0);
    if (m_over) over_and_restart();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({obs(), winner} !== {expv(S_IDLE, 1'b1, 0, 0, 1'b0), 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset_play got=%h", {obs(), winner});
    end
    #2;
    rst_n = 1'b1;
    m_l = 0;
    m_r = 0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_cmp++;
    if (obs() !== expv(S_SERVE, 1'b1, 0, 0, 1'b0)) begin
      n_fail++;
      $display("FAIL pre_reset_serve got=%h", obs());
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({obs(), winner} !== {expv(S_IDLE, 1'b1, 0, 0, 1'b0), 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset_serve got=%h", {obs(), winner});
    end
    #2;
    rst_n = 1'b1;
    repeat (SC + 2) tick();
    n_cmp++;
    if (obs() !== expv(S_IDLE, 1'b1, 0, 0, 1'b0)) begin
      n_fail++;
      $display("FAIL post_reset_idle got=%h", obs());
    end
  endtask

`ifdef GAME_CTL_PAUSE_EN
  task automatic test_pause();
    restart();
    pause = 1'b1;
    ball_xpos = 11'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (obs() !== expv(S_PAUSE, 1'b1, 0, 0, 1'b0)) begin
        n_fail++;
        $display("FAIL pause_hold cycle=%0d got=%h", i, obs());
      end
    end
    pause = 1'b0;
    ball_xpos = 11'd400;
    for (int i = 1; i <= SC + 1; i++) begin
      tick();
      n_cmp++;
      if (obs() !== ((i <= SC) ? expv(S_SERVE, 1'b1, 0, 0, 1'b0) : expv(S_PLAY, 1'b0, 0, 0, 1'b0))) begin
        n_fail++;
        $display("FAIL pause_release cycle=%0d got=%h", i, obs());
      end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef GAME_CTL_PAUSE_EN
    pause = 1'b0;
`endif
    test_reset();
    test_start_edge();
    test_miss_decode();
    test_win();
    test_random();
    test_async_reset();
`ifdef GAME_CTL_PAUSE_EN
    test_pause();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
